// File: rtl/rst_seq_ctrl_pkg.sv
// Shared state type, default parameters and helpers for the rst_seq_ctrl reset sequencer.
package rst_seq_ctrl_pkg;

    localparam int DEF_HOLD_CYCLES   = 10;
    localparam int DEF_SETTLE_CYCLES = 10;
    localparam int DEF_DIV_W         = 16;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_GATED   = 3'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_clk_en_div.sv
// Clock-enable divider: holds div_q and the free-running count that produces enable pulses.
module clk_en_div
    import rst_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_load,
    input  logic             advance,
    output logic             hit
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // The count only advances while the FSM stays in RUN, so it is zero on every RUN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (div_load) begin
                div_q <= div_value;
            end
            if (advance && !hit) begin
                cnt <= cnt + DIV_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign hit = (cnt >= div_q);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Peripheral reset sequencer: ASSERT -> RELEASE -> RUN/GATED, with a divided clock enable.
// Define RST_SEQ_CTRL_CNT_EN to add the saturating software-reset counter output rst_cnt_o.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DIV_W         = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sw_rst_i,
    input  logic             gate_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             periph_rst_o,
    output logic             periph_clk_en_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [2:0]       state_o
`ifdef RST_SEQ_CTRL_CNT_EN
    ,
    output logic [15:0]      rst_cnt_o
`endif
);

    localparam int TIMER_W = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               sw_rst_take;
    logic               div_hit;
    logic               cnt_advance;

    // A software request during ASSERT is dropped so it cannot stretch the hold time.
    assign sw_rst_take = sw_rst_i && (state_q != ST_ASSERT);
    assign cnt_advance = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ASSERT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        if (sw_rst_take) begin
            state_d = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (timer_q == HOLD_LAST) state_d = ST_RELEASE;
                    else                      timer_d = timer_q + TIMER_W'(1);
                end
                ST_RELEASE: begin
                    if (timer_q == SETTLE_LAST) state_d = ST_RUN;
                    else                        timer_d = timer_q + TIMER_W'(1);
                end
                ST_RUN: begin
                    if (gate_i) state_d = ST_GATED;
                end
                ST_GATED: begin
                    if (!gate_i) state_d = ST_RUN;
                end
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    always_comb begin
        periph_rst_o    = 1'b0;
        periph_clk_en_o = 1'b0;
        busy_o          = 1'b0;
        ready_o         = 1'b0;
        state_o         = state_q;
        case (state_q)
            ST_ASSERT: begin
                periph_rst_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_RELEASE: busy_o = 1'b1;
            ST_RUN: begin
                ready_o         = 1'b1;
                periph_clk_en_o = div_hit;
            end
            ST_GATED: ;
            default: begin
                periph_rst_o = 1'b1;
                busy_o       = 1'b1;
            end
        endcase
    end

    clk_en_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk       (clk_i),
        .rst       (rst_i),
        .div_value (div_i),
        .div_load  (div_load_i),
        .advance   (cnt_advance),
        .hit       (div_hit)
    );

`ifdef RST_SEQ_CTRL_CNT_EN
    logic [15:0] rst_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cnt_q <= '0;
        end else if (sw_rst_take && (rst_cnt_q != 16'hFFFF)) begin
            rst_cnt_q <= rst_cnt_q + 16'd1;
        end
    end

    assign rst_cnt_o = rst_cnt_q;
`else
    // Counter build option disabled: sw_rst_i only steers the FSM.
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios, then random stimulus vs. a timeline model.
module tb_rst_seq_ctrl;

    localparam int HOLD   = 10;
    localparam int SETTLE = 10;
    localparam int DW     = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sw_rst_i = 1'b0;
    logic          gate_i = 1'b0;
    logic [DW-1:0] div_i = '0;
    logic          div_load_i = 1'b0;
    logic          periph_rst_o;
    logic          periph_clk_en_o;
    logic          busy_o;
    logic          ready_o;
    logic [2:0]    state_o;
`ifdef RST_SEQ_CTRL_CNT_EN
    logic [15:0]   rst_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // Model: age = cycles since the sequence (re)started, since = cycles since RUN entry or last pulse.
    int age    = 0;
    int since  = 0;
    int m_div  = 0;
    int rcnt   = 0;
    bit gated  = 1'b0;
    int cyc    = 0;

    rst_seq_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .DIV_W         (DW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sw_rst_i        (sw_rst_i),
        .gate_i          (gate_i),
        .div_i           (div_i),
        .div_load_i      (div_load_i),
        .periph_rst_o    (periph_rst_o),
        .periph_clk_en_o (periph_clk_en_o),
        .busy_o          (busy_o),
        .ready_o         (ready_o),
        .state_o         (state_o)
`ifdef RST_SEQ_CTRL_CNT_EN
        ,
        .rst_cnt_o       (rst_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_phase();
        if (age < HOLD)               return 0;
        else if (age < HOLD + SETTLE) return 1;
        else if (gated)               return 3;
        else                          return 2;
    endfunction

    task automatic model_edge(input bit rst, input bit sw, input bit gate,
                              input bit load, input int dv);
        int p;
        bit pulse;
        p     = model_phase();
        pulse = (p == 2) && (since >= m_div);
        if (rst) begin
            age = 0; gated = 0; since = 0; m_div = 0; rcnt = 0;
        end else begin
            if (sw && p != 0) begin
                age = 0; gated = 0; since = 0;
                if (rcnt < 65535) rcnt++;
            end else begin
                if (age < 100000) age++;
                if (p == 2 && !gate) since = pulse ? 0 : since + 1;
                else                 since = 0;
                if (p == 2 && gate)  gated = 1;
                if (p == 3 && !gate) gated = 0;
            end
            if (load) m_div = dv;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_output();
        int p;
        p = model_phase();
        check_val("periph_rst", periph_rst_o, (p == 0));
        check_val("clk_en", periph_clk_en_o, ((p == 2) && (since >= m_div)));
        check_val("busy", busy_o, (p < 2));
        check_val("ready", ready_o, (p == 2));
        check_val("state", state_o, p);
`ifdef RST_SEQ_CTRL_CNT_EN
        check_val("rst_cnt", rst_cnt_o, rcnt);
`endif
    endtask

    task automatic apply_stimulus(input bit rst, input bit sw, input bit gate,
                                  input bit load, input int dv);
        rst_i = rst; sw_rst_i = sw; gate_i = gate; div_load_i = load; div_i = DW'(dv);
        @(posedge clk_i);
        model_edge(rst, sw, gate, load, dv);
        #1;
        check_output();
        cyc++;
    endtask

    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 60 && periph_rst_o; i++) begin
            n++;
            apply_stimulus(0, 0, 0, 0, 0);
        end
    endtask

    task automatic count_settle(output int n);
        n = 0;
        for (int i = 0; i < 60 && busy_o && !periph_rst_o; i++) begin
            n++;
            apply_stimulus(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int first_low, first_ready, np, n;
        int pulse_cyc [3];
        bit g;

        // Power-on reset for 5 cycles, then the default sequence with div 3.
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 0);
        cyc = 1;
        first_low = 0; first_ready = 0; np = 0;
        for (int i = 0; i < 3; i++) pulse_cyc[i] = 0;
        for (int c = 2; c <= 34; c++) begin
            apply_stimulus(0, 0, 0, (c == 3), 3);
            if (!periph_rst_o && first_low == 0) first_low = c;
            if (ready_o && first_ready == 0) first_ready = c;
            if (periph_clk_en_o && np < 3) begin
                pulse_cyc[np] = c;
                np++;
            end
        end
        check_val("rst_fall_cycle", first_low, 11);
        check_val("ready_cycle", first_ready, 21);
        check_val("pulse0_cycle", pulse_cyc[0], 24);
        check_val("pulse1_cycle", pulse_cyc[1], 28);
        check_val("pulse2_cycle", pulse_cyc[2], 32);

        // Divider of zero: enable every cycle.
        apply_stimulus(0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 0, 0, 0);
            if (periph_clk_en_o) n++;
        end
        check_val("div0_pulses", n, 6);

        // Gating with div 3, then resume latency.
        apply_stimulus(0, 0, 0, 1, 3);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 1, 0, 0);
        check_val("gated_state", state_o, 3);
        n = 0;
        do begin
            apply_stimulus(0, 0, 0, 0, 0);
            n++;
        end while (!periph_clk_en_o && n < 20);
        check_val("gate_resume_latency", n, 4);

        // Software reset from RUN, with sw+gate together.
        apply_stimulus(0, 1, 1, 0, 0);
        count_hold(n);
        check_val("sw_hold_len", n, HOLD);
        count_settle(n);
        check_val("sw_settle_len", n, SETTLE);

        // Software reset inside ASSERT is ignored; inside RELEASE it restarts.
        apply_stimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        count_hold(n);
        check_val("assert_ignores_sw", n, HOLD - 4);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        count_hold(n);
        check_val("release_sw_restart", n, HOLD);
        count_settle(n);
        check_val("release_sw_settle", n, SETTLE);

        // Divider reload mid-count: 9 -> 7 at cnt 5, then 9 -> 2 at cnt 5.
        apply_stimulus(0, 0, 0, 1, 9);
        for (int i = 0; i < 40 && !periph_clk_en_o; i++) apply_stimulus(0, 0, 0, 0, 0);
        check_val("div9_pulse_seen", periph_clk_en_o, 1);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 7);
        check_val("reload7_no_early", periph_clk_en_o, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_val("reload7_pulse", periph_clk_en_o, 1);
        apply_stimulus(0, 0, 0, 1, 9);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 2);
        check_val("reload2_next", periph_clk_en_o, 1);

        // Random traffic including mid-sequence resets.
        g = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) g = ~g;
            apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), g,
                           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: number of cycles periph_rst_o is held asserted (>=1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 10: number of cycles after reset release before the clock enable starts (>=1).
REQ-003 SHALL have parameter DIV_W, default 16: divider width.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_i  in  1  synchronous reset, active-high.
REQ-006 SHALL have port sw_rst_i  in  1  software reset request, one-cycle pulse.
REQ-007 SHALL have port gate_i  in  1  level; high suspends clock-enable pulses while in RUN.
REQ-008 SHALL have port div_i  in  DIV_W  divider value.
REQ-009 SHALL have port div_load_i  in  1  loads div_i into div_q.
REQ-010 SHALL have port periph_rst_o  out  1  active-high synchronous reset to the peripheral.
REQ-011 SHALL have port periph_clk_en_o  out  1  clock-enable pulse to the peripheral.
REQ-012 SHALL have port busy_o  out  1  high in ASSERT or RELEASE.
REQ-013 SHALL have port ready_o  out  1  high in RUN.
REQ-014 SHALL have port state_o  out  3  current state encoding.

Function
REQ-015 SHALL implement states ASSERT=0, RELEASE=1, RUN=2, GATED=3.
REQ-016 ASSERT SHALL drive periph_rst_o=1 and periph_clk_en_o=0; after HOLD_CYCLES cycles -> RELEASE.
REQ-017 RELEASE SHALL drive periph_rst_o=0 and periph_clk_en_o=0; after SETTLE_CYCLES cycles -> RUN.
REQ-018 On entry to RUN, the divider counter cnt SHALL be 0; periph_clk_en_o = (cnt >= div_q); cnt SHALL clear on a pulse and otherwise increment.
REQ-019 div_q=0 SHALL give periph_clk_en_o continuously high in RUN.
REQ-020 div_load_i SHALL update div_q on the next edge in any state; the compare SHALL use the new value immediately, so new div_q <= cnt pulses next cycle.
REQ-021 RUN with gate_i=1 SHALL go to GATED: no pulses, periph_rst_o=0, cnt held at 0.
REQ-022 GATED with gate_i=0 SHALL return to RUN with cnt=0.
REQ-023 sw_rst_i in RELEASE, RUN or GATED SHALL move to ASSERT on the next edge with the timer cleared; sw_rst_i in ASSERT SHALL be ignored (no extension).
REQ-024 If sw_rst_i and gate_i are high together, sw_rst_i SHALL win.
REQ-025 Outputs SHALL be decoded from registered state/cnt only (no input-to-output combinational path).
REQ-026 The state timer width SHALL be $clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1); the timer SHALL not wrap.

Reset
REQ-027 rst_i SHALL force ASSERT, timer=0, cnt=0, div_q=0.
REQ-028 During and after rst_i: periph_rst_o=1, periph_clk_en_o=0, busy_o=1, ready_o=0, state_o=0.
REQ-029 periph_rst_o SHALL stay high exactly HOLD_CYCLES cycles after the last cycle rst_i is sampled high; rst_i mid-sequence SHALL restart from ASSERT.

Configuration
REQ-030 With RST_SEQ_CTRL_CNT_EN defined, the block SHALL have output rst_cnt_o[15:0]: incremented on each sw_rst_i-caused ASSERT entry, saturating at 0xFFFF, cleared by rst_i.
REQ-031 Without RST_SEQ_CTRL_CNT_EN, rst_cnt_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package rst_seq_ctrl_pkg SHALL hold the state enum typedef (3-bit) and default constants for HOLD_CYCLES, SETTLE_CYCLES and DIV_W.
REQ-033 Sub-module clk_en_div SHALL implement cnt, div_q and the pulse compare; the FSM stays in rst_seq_ctrl.

Verification
REQ-034 rst_i high 5 cycles then low, div_i=3 loaded in cycle 2:
  - periph_rst_o=1 in cycles 1-10, 0 from cycle 11.
  - ready_o=1 from cycle 21.
  - periph_clk_en_o pulses at cycles 24, 28, 32.
REQ-035 div_q=0 in RUN -> periph_clk_en_o=1 every cycle.
REQ-036 div=3, gate_i high for 7 cycles in RUN -> no pulses, state_o=3; gate_i low -> state_o=2, first pulse 4 cycles later.
REQ-037 sw_rst_i pulse in RUN -> next cycle periph_rst_o=1, busy_o=1; ASSERT 10 cycles, RELEASE 10 cycles, then RUN; with macro, rst_cnt_o 0->1.
REQ-038 sw_rst_i in ASSERT cycle 5 -> release still at cycle 10; sw_rst_i in RELEASE cycle 15 -> ASSERT restarts for 10 cycles.
REQ-039 Divider reload, div_q=9 with cnt=5:
  - load 7 -> pulse when cnt=7.
  - load 2 -> pulse the next cycle.
